tuart_tx_fifo: RTL and testbench

Parametrised successor of the logIP UART transmitter. Accepts DATA_W-bit sample words through a FIFO and serialises only the byte lanes enabled by a per-word mask, LSB byte first. Provides a runtime baud divider, optional parity, 1 or 2 stop bits and XON/XOFF pause at byte boundaries. Sits between the sampler/readout path and the host UART pin.

---
 rtl/tuart_tx_fifo_if.sv | 9 +
 rtl/tuart_tx_fifo.sv | 112 +++++++++++
 tb/tb_tuart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tuart_tx_fifo_if.sv
// tuart_tx_fifo_if: word write port into the UART transmit FIFO
interface tuart_tx_fifo_if #(parameter int DATA_W = 32) ();
  logic              stb_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W/8-1:0] bmask_i;
  logic              rdy_o;
  modport master (output stb_i, data_i, bmask_i, input rdy_o);
  modport slave  (input stb_i, data_i, bmask_i, output rdy_o);
endinterface

// File: rtl/tuart_tx_fifo.sv
// tuart_tx_fifo: FIFO-fed UART transmitter sending masked byte lanes LSB byte first
module tuart_tx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  tuart_tx_fifo_if.slave             wr,
  input  logic [DIV_W-1:0]           div_i,
  input  logic [1:0]                 parity_i,
  input  logic                       stop2_i,
  input  logic                       xstb_i,
  input  logic                       xon_i,
  input  logic                       xoff_i,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int NB = DATA_W / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP, NEXT} state_t;
  state_t st, nxt;
  logic [NB+DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] wrd;
  logic [NB-1:0]     msk;
  logic [7:0]        sh, sel_byte;
  logic [2:0]        bidx;
  logic [DIV_W-1:0]  cnt, div_l;
  logic              par_en, par_bit, stop2_l, stop_more, paused;
  logic              any, go, ldr, full, empty, push, pop, bit_end;
  logic [IW-1:0]     idx;
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NB - 1; k >= 0; k--)
      if (msk[k]) begin
        any = 1'b1;
        idx = IW'(k);
      end
  end
  assign sel_byte   = wrd[{idx, 3'b000} +: 8];
  assign empty      = level == '0;
  assign full       = level == LW'(DEPTH);
  assign push       = wr.stb_i && !full;
  assign pop        = st == IDLE && !empty;
  assign go         = any && !paused;
  // NEXT makes the same lane choice as LOAD so back-to-back bytes get a single idle clock
  assign ldr        = (st == LOAD || st == NEXT) && go;
  assign bit_end    = cnt == '0;
  assign wr.rdy_o   = !full;
  assign level_o    = level;
  assign busy_o     = st != IDLE;
  assign tx_o       = st == START ? 1'b0 : st == DATA ? sh[0] : st == PARITY ? par_bit : 1'b1;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = empty ? IDLE : LOAD;
      LOAD:    nxt = !any ? IDLE : paused ? LOAD : START;
      START:   nxt = bit_end ? DATA : START;
      DATA:    nxt = bit_end && bidx == 3'd7 ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  nxt = bit_end ? STOP : PARITY;
      STOP:    nxt = bit_end && !stop_more ? NEXT : STOP;
      NEXT:    nxt = go ? START : LOAD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= {wr.bmask_i, wr.data_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st        <= IDLE;
      paused    <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      cnt       <= '0;
      stop_more <= 1'b0;
    end else begin
      st <= nxt;
      if (xstb_i) paused <= xoff_i | (paused & ~xon_i);
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        {msk, wrd} <= mem[rptr];
        rptr       <= rptr + 1'b1;
      end
      level <= level + LW'(push) - LW'(pop);
      if (ldr) begin
        div_l    <= div_i;
        cnt      <= div_i;
        par_en   <= parity_i == 2'b01 || parity_i == 2'b10;
        par_bit  <= ^sel_byte ^ (parity_i == 2'b01);
        stop2_l  <= stop2_i;
        msk[idx] <= 1'b0;
        sh       <= sel_byte;
        bidx     <= '0;
      end else if (st inside {START, DATA, PARITY, STOP}) begin
        cnt <= bit_end ? div_l : cnt - 1'b1;
        if (st == DATA && bit_end) begin
          sh   <= sh >> 1;
          bidx <= bidx + 1'b1;
        end
        if (st == STOP && bit_end) stop_more <= 1'b0;
        else if (st != STOP && nxt == STOP) stop_more <= stop2_l;
      end
    end
  end
endmodule

// File: tb/tb_tuart_tx_fifo.sv
// tb_tuart_tx_fifo: randomized bench decoding the serial line against a byte-queue model
module tb_tuart_tx_fifo;
  localparam int DATA_W = 32, DEPTH = 8, DIV_W = 16;
  logic clk = 1'b0, rst_i = 1'b0;
  logic [DIV_W-1:0] div_i;
  logic [1:0] parity_i;
  logic stop2_i, xstb_i, xon_i, xoff_i, tx_o, busy_o;
  logic [3:0] level_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tuart_tx_fifo_if #(.DATA_W(DATA_W)) wif ();
  tuart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr(wif), .div_i(div_i), .parity_i(parity_i),
    .stop2_i(stop2_i), .xstb_i(xstb_i), .xon_i(xon_i), .xoff_i(xoff_i),
    .tx_o(tx_o), .busy_o(busy_o), .level_o(level_o));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] m);
    wif.stb_i = 1'b1; wif.data_i = d; wif.bmask_i = m;
    tick;
    wif.stb_i = 1'b0;
  endtask

  task automatic pulse_x(input logic on, input logic off);
    xstb_i = 1'b1; xon_i = on; xoff_i = off;
    tick;
    xstb_i = 1'b0; xon_i = 1'b0; xoff_i = 1'b0;
  endtask

  // UART receiver: counts idle-high clocks, then requires every bit to hold for div+1 clocks
  task automatic rx_frame(input bit pe, input bit s2, output logic [7:0] b, output logic pb,
                          output int idle, output bit ok);
    int n, dv;
    logic v;
    dv = int'(div_i); ok = 1; idle = 0; b = '0; pb = 1'b0;
    while (tx_o === 1'b1 && idle < 4000) begin tick; idle++; end
    if (tx_o !== 1'b0) begin ok = 0; return; end
    n = 10 + int'(pe) + int'(s2);
    for (int i = 0; i < n; i++) begin
      v = tx_o;
      for (int j = 0; j <= dv; j++) begin
        if (tx_o !== v) ok = 0;
        tick;
      end
      if (i >= 1 && i <= 8) b[i-1] = v;
      else if (pe && i == 9) pb = v;
      else if (i > 0 && v !== 1'b1) ok = 0;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 200) begin tick; n++; end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick;
    checks++; if ({tx_o, busy_o, level_o, wif.rdy_o} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_state: got tx/busy/level/rdy %b/%b/%0d/%b expected 1/0/0/1", tx_o, busy_o, level_o, wif.rdy_o); end
    rst_i = 1'b0;
    tick;
  endtask

  task automatic test_single;
    logic [7:0] b; logic pb; int idle, n; bit ok; logic [31:0] r;
    div_i = 3; parity_i = 2'b00; stop2_i = 1'b0;
    r = $urandom;
    push({r[31:8], 8'hA5}, 4'b0001);
    rx_frame(0, 0, b, pb, idle, ok);
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", b); end
    checks++; if (idle != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", idle); end
    checks++; if (!ok) begin errors++; $display("FAIL single_framing: got bad expected good"); end
    wait_idle(n);
    checks++; if (n != 2) begin errors++; $display("FAIL single_busy_drop: got %0d expected 2", n); end
  endtask

  task automatic test_parity;
    logic [7:0] b, d; logic pb; int idle, n; bit ok, pe;
    for (int i = 0; i < 10; i++) begin
      d = i < 3 ? 8'hA5 : 8'($urandom);
      div_i = i < 3 ? 16'd3 : 16'($urandom_range(0, 3));
      parity_i = i == 0 ? 2'b10 : i == 1 ? 2'b01 : i == 2 ? 2'b10 : 2'($urandom);
      stop2_i = i == 2 ? 1'b1 : i < 2 ? 1'b0 : 1'($urandom);
      pe = parity_i == 2'b01 || parity_i == 2'b10;
      push({24'h0, d}, 4'b0001);
      rx_frame(pe, stop2_i, b, pb, idle, ok);
      checks++; if (b !== d || !ok || idle != 2) begin errors++;
        $display("FAIL parity_frame%0d: got %h ok=%0d idle=%0d expected %h ok=1 idle=2", i, b, ok, idle, d); end
      if (pe) begin
        checks++; if (pb !== (^d ^ (parity_i == 2'b01))) begin errors++;
          $display("FAIL parity_bit%0d: got %b expected %b", i, pb, ^d ^ (parity_i == 2'b01)); end
      end
      wait_idle(n);
      checks++; if (n != 2) begin errors++; $display("FAIL parity_busy_drop%0d: got %0d expected 2", i, n); end
    end
  endtask

  task automatic test_mask;
    logic [7:0] b; logic pb; int idle, n; bit ok, hi;
    div_i = 16'($urandom_range(0, 3)); parity_i = 2'b00; stop2_i = 1'b0;
    push(32'h44332211, 4'b1010);
    rx_frame(0, 0, b, pb, idle, ok);
    checks++; if (b !== 8'h22 || idle != 2 || !ok) begin errors++;
      $display("FAIL mask_first: got %h idle=%0d ok=%0d expected 22 idle=2 ok=1", b, idle, ok); end
    rx_frame(0, 0, b, pb, idle, ok);
    checks++; if (b !== 8'h44 || idle != 1 || !ok) begin errors++;
      $display("FAIL mask_second: got %h idle=%0d ok=%0d expected 44 idle=1 ok=1", b, idle, ok); end
    wait_idle(n);
    checks++; if (n != 2) begin errors++; $display("FAIL mask_busy_drop: got %0d expected 2", n); end
    push($urandom, 4'b0000);
    checks++; if (level_o !== 4'd1) begin errors++; $display("FAIL mask0_level_in: got %0d expected 1", level_o); end
    tick;
    checks++; if (level_o !== 4'd0 || busy_o !== 1'b1) begin errors++;
      $display("FAIL mask0_pop: got level=%0d busy=%b expected 0/1", level_o, busy_o); end
    hi = 1;
    for (int i = 0; i < 12; i++) begin if (tx_o !== 1'b1) hi = 0; tick; end
    checks++; if (!hi || busy_o !== 1'b0) begin errors++;
      $display("FAIL mask0_quiet: got line_high=%0d busy=%b expected 1/0", hi, busy_o); end
  endtask

  task automatic test_full;
    logic [7:0] b, e; logic pb; int idle, n, mlevel; bit ok, pe, mheld, acc, pp;
    logic [31:0] d; logic [3:0] m;
    logic [7:0] expq[$];
    div_i = 1; parity_i = 2'($urandom); stop2_i = 1'b0;
    pe = parity_i == 2'b01 || parity_i == 2'b10;
    mlevel = 0; mheld = 0;
    pulse_x(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      checks++; if (wif.rdy_o !== (mlevel < DEPTH)) begin errors++;
        $display("FAIL full_rdy%0d: got %b expected %b", k, wif.rdy_o, mlevel < DEPTH); end
      d = $urandom; m = 4'($urandom_range(1, 15));
      push(d, m);
      acc = mlevel < DEPTH;
      pp = !mheld && mlevel > 0;
      mlevel = mlevel + int'(acc) - int'(pp);
      mheld |= pp;
      if (acc) for (int j = 0; j < 4; j++) if (m[j]) expq.push_back(d[8*j +: 8]);
      checks++; if (level_o !== 4'(mlevel)) begin errors++;
        $display("FAIL full_level%0d: got %0d expected %0d", k, level_o, mlevel); end
    end
    checks++; if (level_o !== 4'd8 || wif.rdy_o !== 1'b0 || tx_o !== 1'b1) begin errors++;
      $display("FAIL full_hold: got level=%0d rdy=%b tx=%b expected 8/0/1", level_o, wif.rdy_o, tx_o); end
    pulse_x(1'b1, 1'b0);
    n = 0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      rx_frame(pe, 0, b, pb, idle, ok);
      checks++; if (b !== e || !ok) begin errors++;
        $display("FAIL full_byte%0d: got %h ok=%0d expected %h ok=1", n, b, ok, e); end
      if (pe) begin
        checks++; if (pb !== (^e ^ (parity_i == 2'b01))) begin errors++;
          $display("FAIL full_parity%0d: got %b expected %b", n, pb, ^e ^ (parity_i == 2'b01)); end
      end
      n++;
    end
    wait_idle(n);
    checks++; if (level_o !== 4'd0 || busy_o !== 1'b0 || wif.rdy_o !== 1'b1) begin errors++;
      $display("FAIL full_drain: got level=%0d busy=%b rdy=%b expected 0/0/1", level_o, busy_o, wif.rdy_o); end
  endtask

  task automatic test_xoff_mid;
    logic [7:0] b; logic pb; int idle, n; bit ok, hi; logic [31:0] d;
    div_i = 16'($urandom_range(1, 3)); parity_i = 2'b00; stop2_i = 1'b0;
    d = $urandom;
    push(d, 4'b1111);
    rx_frame(0, 0, b, pb, idle, ok);
    checks++; if (b !== d[7:0] || !ok) begin errors++; $display("FAIL xoff_byte0: got %h expected %h", b, d[7:0]); end
    fork
      rx_frame(0, 0, b, pb, idle, ok);
      begin repeat (1 + 3 * (int'(div_i) + 1)) tick; pulse_x(1'b0, 1'b1); end
    join
    checks++; if (b !== d[15:8] || !ok || idle != 1) begin errors++;
      $display("FAIL xoff_byte1_completes: got %h ok=%0d idle=%0d expected %h ok=1 idle=1", b, ok, idle, d[15:8]); end
    hi = 1;
    for (int i = 0; i < 20; i++) begin if (tx_o !== 1'b1 || busy_o !== 1'b1) hi = 0; tick; end
    checks++; if (!hi) begin errors++; $display("FAIL xoff_hold: got line activity expected high and busy"); end
    pulse_x(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin if (tx_o !== 1'b1 || busy_o !== 1'b1) hi = 0; tick; end
    checks++; if (!hi) begin errors++; $display("FAIL xoff_wins: got line activity expected still paused"); end
    pulse_x(1'b1, 1'b0);
    rx_frame(0, 0, b, pb, idle, ok);
    checks++; if (b !== d[23:16] || !ok || idle != 1) begin errors++;
      $display("FAIL xon_resume: got %h ok=%0d idle=%0d expected %h ok=1 idle=1", b, ok, idle, d[23:16]); end
    rx_frame(0, 0, b, pb, idle, ok);
    checks++; if (b !== d[31:24] || !ok || idle != 1) begin errors++;
      $display("FAIL xon_byte3: got %h ok=%0d idle=%0d expected %h", b, ok, idle, d[31:24]); end
    wait_idle(n);
    checks++; if (n != 2) begin errors++; $display("FAIL xon_busy_drop: got %0d expected 2", n); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b; logic pb; int idle, n; bit ok, hi; logic [7:0] d;
    div_i = 2; parity_i = 2'b00; stop2_i = 1'b0;
    for (int k = 0; k < 4; k++) push($urandom, 4'($urandom_range(1, 15)));
    n = 0;
    while (tx_o !== 1'b0 && n < 100) begin tick; n++; end
    checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b expected 0", tx_o); end
    repeat (3 * (int'(div_i) + 1) + 1) tick;
    pulse_x(1'b0, 1'b1);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    checks++; if ({tx_o, busy_o, level_o, wif.rdy_o} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin errors++;
      $display("FAIL rstmid_state: got tx/busy/level/rdy %b/%b/%0d/%b expected 1/0/0/1", tx_o, busy_o, level_o, wif.rdy_o); end
    hi = 1;
    for (int i = 0; i < 100; i++) begin if (tx_o !== 1'b1 || busy_o !== 1'b0) hi = 0; tick; end
    checks++; if (!hi) begin errors++; $display("FAIL rstmid_quiet: got line activity expected idle"); end
    d = 8'($urandom);
    push({24'h0, d}, 4'b0001);
    rx_frame(0, 0, b, pb, idle, ok);
    checks++; if (b !== d || idle != 2 || !ok) begin errors++;
      $display("FAIL rstmid_unpaused: got %h idle=%0d ok=%0d expected %h idle=2 ok=1", b, idle, ok, d); end
    wait_idle(n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wif.stb_i = 1'b0; wif.data_i = '0; wif.bmask_i = '0;
    div_i = 3; parity_i = 2'b00; stop2_i = 1'b0;
    xstb_i = 1'b0; xon_i = 1'b0; xoff_i = 1'b0;
    tick;
    test_reset;
    test_single;
    test_parity;
    test_mask;
    test_full;
    test_xoff_mid;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
